// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply / divide engine.
// Radix-2, one iteration per clock. Multiply is shift-add; divide is
// restoring. Both run on operand magnitudes and apply sign correction in FIX.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   mult_start   one-cycle request for signed a*b
//   div_start    one-cycle request for signed a/b (mult_start wins if both)
//   a, b         operands rs / rt
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle pulse; hi_out/lo_out valid in this cycle
//   hi_out       MULT: product upper half; DIV: remainder
//   lo_out       MULT: product lower half; DIV: quotient
//   div_by_zero  set with done for DIV by zero; held until next accepted start
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_next;

  logic             op_mult;
  logic             op_div0;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] acc_hi;   // MULT: P (upper product); DIV: R (remainder)
  logic [WIDTH-1:0] acc_lo;   // MULT: Q (multiplier/lower); DIV: Q (quotient)
  logic [CNT_W-1:0] counter;
  logic             fix_wait;

  logic start_accept;
  logic start_div0;

  // Magnitude of a two's-complement value; the most negative value maps to
  // 2^(WIDTH-1), which still fits when read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  assign start_accept = (state == IDLE) && (mult_start || div_start);
  assign start_div0   = !mult_start && div_start && (b == '0);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_accept) begin
          state_next = start_div0 ? FIX : CALC;
        end
      end
      CALC: begin
        if (counter == CNT_W'(WIDTH - 1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        // Divide-by-zero spends two cycles in FIX so that done lands on the
        // third cycle after the start sample.
        if (op_div0 && !fix_wait) begin
          state_next = FIX;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC:    busy = 1'b1;
      FIX:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;

  always_comb begin
    mul_addend = acc_lo[0] ? {1'b0, b_mag} : '0;
    mul_sum    = {1'b0, acc_hi} + mul_addend;
    div_shift  = {acc_hi, acc_lo[WIDTH-1]};
    div_diff   = {1'b0, div_shift} - {2'b00, b_mag};
    div_ge     = !div_diff[WIDTH+1];
  end

  // ---------------------------------------------------------------------
  // Sign correction
  // ---------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod_mag   = {acc_hi, acc_lo};
    prod_fixed = (sign_a ^ sign_b) ? -prod_mag : prod_mag;
    quo_fixed  = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
    rem_fixed  = sign_a ? -acc_hi : acc_hi;
    if (op_mult) begin
      fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
      fix_lo = prod_fixed[WIDTH-1:0];
    end else if (op_div0) begin
      fix_hi = a_lat;
      fix_lo = '1;
    end else begin
      fix_hi = rem_fixed;
      fix_lo = quo_fixed;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_mult     <= 1'b0;
      op_div0     <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      a_lat       <= '0;
      b_mag       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      counter     <= '0;
      fix_wait    <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_accept) begin
            op_mult     <= mult_start;
            op_div0     <= start_div0;
            sign_a      <= a[WIDTH-1];
            sign_b      <= b[WIDTH-1];
            a_lat       <= a;
            b_mag       <= magnitude(b);
            acc_hi      <= '0;
            acc_lo      <= magnitude(a);
            counter     <= '0;
            fix_wait    <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          counter <= counter + CNT_W'(1);
          if (op_mult) begin
            // {carry,P,Q} >> 1
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end else if (div_ge) begin
            acc_hi <= div_diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          fix_wait    <= 1'b1;
          hi_out      <= fix_hi;
          lo_out      <= fix_lo;
          div_by_zero <= op_div0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32).
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_by_zero;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .mult_start  (mult_start),
    .div_start   (div_start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_by_zero (div_by_zero)
  );

  // Reference model: plain signed 64-bit arithmetic.
  task automatic model(input bit is_mult, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output logic edz,
                       output int elat);
    longint      sx;
    longint      sy;
    logic [63:0] pv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    edz  = 1'b0;
    elat = 34;
    if (is_mult) begin
      pv = sx * sy;
      eh = pv[63:32];
      el = pv[31:0];
    end else if (y == 32'd0) begin
      eh   = x;
      el   = 32'hFFFF_FFFF;
      edz  = 1'b1;
      elat = 3;
    end else begin
      pv = sx / sy;
      el = pv[31:0];
      pv = sx % sy;
      eh = pv[31:0];
    end
  endtask

  // Waits for IDLE, issues one start, follows the op to done.
  // lat=999 means done never arrived within the cycle budget.
  task automatic run_op(input bit m, input bit d, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] h, output logic [31:0] l,
                        output logic dz, output int busy_bad, output logic dz_t1);
    int w;
    int n;
    w = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || done !== 1'b0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    mult_start = m;
    div_start  = d;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    n        = 1;
    lat      = 999;
    busy_bad = 0;
    h        = 'x;
    l        = 'x;
    dz       = 1'bx;
    dz_t1    = div_by_zero;
    while (n <= 100) begin
      if (done === 1'b1) begin
        lat = n;
        h   = hi_out;
        l   = lo_out;
        dz  = div_by_zero;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a          = '0;
    b          = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done got %b want 0", done); end
    n_cmp++; if (hi_out !== 32'd0) begin n_err++; $display("FAIL reset hi_out got %h want 0", hi_out); end
    n_cmp++; if (lo_out !== 32'd0) begin n_err++; $display("FAIL reset lo_out got %h want 0", lo_out); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset div_by_zero got %b want 0", div_by_zero); end
    reset = 1'b0;
  endtask

  task automatic test_directed_case(input int idx, input bit m, input logic [31:0] x,
                                    input logic [31:0] y, input logic [31:0] eh,
                                    input logic [31:0] el, input logic edz, input int elat);
    int          lat;
    int          bb;
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
    logic        dz1;
    run_op(m, !m, x, y, lat, h, l, dz, bb, dz1);
    n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL directed[%0d] latency got %0d want %0d", idx, lat, elat); end
    n_cmp++; if (h !== eh) begin n_err++; $display("FAIL directed[%0d] hi_out got %h want %h", idx, h, eh); end
    n_cmp++; if (l !== el) begin n_err++; $display("FAIL directed[%0d] lo_out got %h want %h", idx, l, el); end
    n_cmp++; if (dz !== edz) begin n_err++; $display("FAIL directed[%0d] div_by_zero got %b want %b", idx, dz, edz); end
    n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL directed[%0d] busy_window got %0d bad cycles want 0", idx, bb); end
  endtask

  task automatic test_directed();
    test_directed_case(0, 1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
    test_directed_case(1, 1'b1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34);
    test_directed_case(2, 1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    test_directed_case(3, 1'b0, 32'd100,        32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0, 34);
    test_directed_case(4, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 34);
    test_directed_case(5, 1'b0, 32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 3);
  endtask

  // Both starts together: multiply wins; a later div_start mid-op is ignored.
  task automatic test_both_starts();
    int n;
    int lat;
    int extra_done;
    int extra_busy;
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
    @(negedge clk);
    while (busy !== 1'b0 || done !== 1'b0) @(negedge clk);
    mult_start = 1'b1;
    div_start  = 1'b1;
    a = 32'd6;
    b = 32'd4;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    n   = 1;
    lat = 999;
    h   = 'x;
    l   = 'x;
    dz  = 1'bx;
    while (n <= 100) begin
      if (n == 10) begin
        div_start = 1'b1;
        a = 32'd100;
        b = 32'd7;
      end else begin
        div_start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = n;
        h   = hi_out;
        l   = lo_out;
        dz  = div_by_zero;
        break;
      end
      @(posedge clk);
      #1;
      n++;
    end
    div_start = 1'b0;
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL both_starts latency got %0d want 34", lat); end
    n_cmp++; if (l !== 32'd24) begin n_err++; $display("FAIL both_starts lo_out got %h want 18", l); end
    n_cmp++; if (h !== 32'd0) begin n_err++; $display("FAIL both_starts hi_out got %h want 0", h); end
    n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL both_starts div_by_zero got %b want 0", dz); end
    extra_done = 0;
    extra_busy = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra_done++;
      if (busy === 1'b1) extra_busy++;
    end
    n_cmp++; if (extra_done !== 0) begin n_err++; $display("FAIL both_starts extra_done got %0d want 0", extra_done); end
    n_cmp++; if (extra_busy !== 0) begin n_err++; $display("FAIL both_starts extra_busy got %0d want 0", extra_busy); end
  endtask

  // A start sampled in the DONE cycle must be dropped.
  task automatic test_start_in_done();
    int          lat;
    int          bb;
    int          busy_seen;
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
    logic        dz1;
    run_op(1'b1, 1'b0, 32'd3, 32'd5, lat, h, l, dz, bb, dz1);
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL start_in_done setup latency got %0d want 34", lat); end
    mult_start = 1'b1;
    a = 32'd11;
    b = 32'd13;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    busy_seen = 0;
    repeat (5) begin
      if (busy === 1'b1) busy_seen++;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (busy_seen !== 0) begin n_err++; $display("FAIL start_in_done busy got %0d cycles want 0", busy_seen); end
    n_cmp++; if (lo_out !== 32'd15) begin n_err++; $display("FAIL start_in_done lo_out_hold got %h want f", lo_out); end
  endtask

  // div_by_zero and results hold after done; the flag clears on the next accepted start.
  task automatic test_hold_and_clear();
    int          lat;
    int          bb;
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
    logic        dz1;
    run_op(1'b0, 1'b1, 32'hDEAD_BEEF, 32'd0, lat, h, l, dz, bb, dz1);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL hold div0 latency got %0d want 3", lat); end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL hold div_by_zero got %b want 1", div_by_zero); end
    n_cmp++; if (hi_out !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL hold hi_out got %h want deadbeef", hi_out); end
    n_cmp++; if (lo_out !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL hold lo_out got %h want ffffffff", lo_out); end
    run_op(1'b1, 1'b0, 32'd2, 32'd3, lat, h, l, dz, bb, dz1);
    n_cmp++; if (dz1 !== 1'b0) begin n_err++; $display("FAIL clear div_by_zero_after_start got %b want 0", dz1); end
    n_cmp++; if (l !== 32'd6) begin n_err++; $display("FAIL clear lo_out got %h want 6", l); end
  endtask

  // Reset in the middle of an operation abandons it.
  task automatic test_reset_mid();
    int          n;
    int          lat;
    int          bb;
    int          late_done;
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
    logic        dz1;
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, lat, h, l, dz, bb, dz1);
    @(negedge clk);
    while (busy !== 1'b0 || done !== 1'b0) @(negedge clk);
    mult_start = 1'b1;
    a = 32'h1234_5678;
    b = 32'd9;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    for (n = 1; n < 5; n++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_mid busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_mid done got %b want 0", done); end
    n_cmp++; if (hi_out !== 32'd0) begin n_err++; $display("FAIL reset_mid hi_out got %h want 0", hi_out); end
    n_cmp++; if (lo_out !== 32'd0) begin n_err++; $display("FAIL reset_mid lo_out got %h want 0", lo_out); end
    late_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) late_done++;
    end
    n_cmp++; if (late_done !== 0) begin n_err++; $display("FAIL reset_mid activity got %0d cycles want 0", late_done); end
    run_op(1'b0, 1'b1, 32'd9, 32'd3, lat, h, l, dz, bb, dz1);
    n_cmp++; if (l !== 32'd3) begin n_err++; $display("FAIL reset_mid div lo_out got %h want 3", l); end
    n_cmp++; if (h !== 32'd0) begin n_err++; $display("FAIL reset_mid div hi_out got %h want 0", h); end
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL reset_mid div latency got %0d want 34", lat); end
  endtask

  function automatic logic [31:0] pick_operand();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return 32'd1;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int          lat;
    int          bb;
    int          elat;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] h;
    logic [31:0] l;
    logic [31:0] eh;
    logic [31:0] el;
    logic        dz;
    logic        dz1;
    logic        edz;
    bit          m;
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      x = pick_operand();
      y = pick_operand();
      model(m, x, y, eh, el, edz, elat);
      run_op(m, !m, x, y, lat, h, l, dz, bb, dz1);
      n_cmp++; if (h !== eh) begin n_err++; $display("FAIL random[%0d] hi_out op=%0d a=%h b=%h got %h want %h", i, m, x, y, h, eh); end
      n_cmp++; if (l !== el) begin n_err++; $display("FAIL random[%0d] lo_out op=%0d a=%h b=%h got %h want %h", i, m, x, y, l, el); end
      n_cmp++; if (dz !== edz) begin n_err++; $display("FAIL random[%0d] div_by_zero got %b want %b", i, dz, edz); end
      n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL random[%0d] latency got %0d want %0d", i, lat, elat); end
      n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL random[%0d] busy_window got %0d bad cycles want 0", i, bb); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_both_starts();
    test_start_in_done();
    test_hold_and_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
